// File: rtl/combat_pkg.sv
// Shared types, tuning constants and the attack lookup for the combat resolver.
// IFRAMES is consumed only when COMBAT_IFRAME_EN is defined.
package combat_pkg;

    localparam int unsigned MAX_HP      = 100;
    localparam int unsigned PUNCH_DMG   = 5;
    localparam int unsigned KICK_DMG    = 10;
    localparam int unsigned BLOCK_SHIFT = 2;
    localparam int unsigned PUNCH_REACH = 30;
    localparam int unsigned KICK_REACH  = 45;
    localparam int unsigned WINDUP_FR   = 3;
    localparam int unsigned ACTIVE_FR   = 2;
    localparam int unsigned RECOVER_FR  = 10;
    localparam int unsigned IFRAMES     = 20;

    // Wide enough for the longest phase load (RECOVER_FR - 1) and for IFRAMES.
    localparam int unsigned CntW = 4;
    localparam int unsigned InvW = 5;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWindup  = 2'd1,
        StActive  = 2'd2,
        StRecover = 2'd3
    } atk_state_t;

    typedef enum logic {
        AtkPunch = 1'b0,
        AtkKick  = 1'b1
    } atk_type_t;

    typedef struct packed {
        logic [9:0] reach;
        logic [7:0] dmg;
    } atk_info_t;

    function automatic atk_info_t atk_info(input atk_type_t t);
        atk_info_t info;
        if (t == AtkKick) begin
            info.reach = 10'(KICK_REACH);
            info.dmg   = 8'(KICK_DMG);
        end else begin
            info.reach = 10'(PUNCH_REACH);
            info.dmg   = 8'(PUNCH_DMG);
        end
        return info;
    endfunction

endpackage

// File: rtl/attack_fsm.sv
// Per-fighter attack sequencer: IDLE -> WINDUP -> ACTIVE -> RECOVER, one attack per key press.
// Owns the frame counter, armed bit, latched attack type and hit-landed latch.
module attack_fsm
    import combat_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       startscreen_i,
    input  logic       halt_i,
    input  logic       punch_i,
    input  logic       kick_i,
    input  logic       block_i,
    input  logic       hit_landed_i,
    output atk_state_t state_o,
    output atk_type_t  type_o,
    output logic       landed_o
);

    atk_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            armed_q, armed_d;
    atk_type_t       type_q, type_d;
    logic            landed_q, landed_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        type_d   = type_q;
        landed_d = landed_q | hit_landed_i;

        // Re-arm only after both attack keys have been seen low.
        if (!punch_i && !kick_i) begin
            armed_d = 1'b1;
        end

        if (startscreen_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            armed_d  = 1'b1;
            landed_d = 1'b0;
        end else if (halt_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (armed_q && (punch_i || kick_i) && !block_i) begin
                        state_d  = StWindup;
                        cnt_d    = CntW'(WINDUP_FR - 1);
                        armed_d  = 1'b0;
                        type_d   = kick_i ? AtkKick : AtkPunch;
                        landed_d = 1'b0;
                    end
                end
                StWindup: begin
                    if (cnt_q == '0) begin
                        state_d = StActive;
                        cnt_d   = CntW'(ACTIVE_FR - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StActive: begin
                    if (cnt_q == '0) begin
                        state_d = StRecover;
                        cnt_d   = CntW'(RECOVER_FR - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StRecover: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            type_q   <= AtkPunch;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            type_q   <= type_d;
            landed_q <= landed_d;
        end
    end

    assign state_o  = state_q;
    assign type_o   = type_q;
    assign landed_o = landed_q;

endmodule

// File: rtl/combat_resolver.sv
// Hit geometry, health bars and death flags for two fighters, fed by two attack_fsm instances.
// Optional invulnerability window after a hit is enabled by defining COMBAT_IFRAME_EN.
module combat_resolver
    import combat_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       startscreen,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_x,
    input  logic [9:0] p2_y,
    input  logic [9:0] p1_l,
    input  logic [9:0] p1_r,
    input  logic [9:0] p1_u,
    input  logic [9:0] p1_d,
    input  logic [9:0] p2_l,
    input  logic [9:0] p2_r,
    input  logic [9:0] p2_u,
    input  logic [9:0] p2_d,
    input  logic       punch_flag1,
    input  logic       kick_flag1,
    input  logic       block_flag1,
    input  logic       punch_flag2,
    input  logic       kick_flag2,
    input  logic       block_flag2,
    output logic [7:0] hp1,
    output logic [7:0] hp2,
    output logic       deathL,
    output logic       deathR,
    output logic       hit1,
    output logic       hit2,
    output logic [1:0] atk_state1,
    output logic [1:0] atk_state2
);

    function automatic logic signed [10:0] gap_f(input logic [9:0] ax, input logic [9:0] aoff,
                                                 input logic [9:0] bx, input logic [9:0] boff);
        return ($signed({1'b0, ax}) - $signed({1'b0, aoff}))
             - ($signed({1'b0, bx}) + $signed({1'b0, boff}));
    endfunction

    function automatic logic signed [11:0] ext_f(input logic [9:0] v);
        return $signed({2'b00, v});
    endfunction

    atk_state_t st1, st2;
    atk_type_t  ty1, ty2;
    logic       landed1, landed2;
    atk_info_t  info1, info2;

    logic [7:0] hp1_q, hp1_d, hp2_q, hp2_d;
    logic       hit1_q, hit1_d, hit2_q, hit2_d;
    logic       dead;
    logic       face1_right;
    logic signed [10:0] gap;
    logic       vert_ovl;
    logic       hit_on1, hit_on2;
    logic [7:0] dmg1, dmg2;
    logic       inv1_clr, inv2_clr;

    assign dead        = (hp1_q == '0) || (hp2_q == '0);
    assign face1_right = p1_x < p2_x;

    // Both fighters always face each other, so the gap and the vertical
    // overlap test come out identical whichever one is attacking.
    assign gap = face1_right ? gap_f(p2_x, p2_l, p1_x, p1_r) : gap_f(p1_x, p1_l, p2_x, p2_r);
    assign vert_ovl = (ext_f(p1_y) + ext_f(p1_d) > ext_f(p2_y) - ext_f(p2_u))
                   && (ext_f(p2_y) + ext_f(p2_d) > ext_f(p1_y) - ext_f(p1_u));

    assign info1 = atk_info(ty1);
    assign info2 = atk_info(ty2);

`ifdef COMBAT_IFRAME_EN
    logic [InvW-1:0] inv1_q, inv1_d, inv2_q, inv2_d;
    assign inv1_clr = (inv1_q == '0);
    assign inv2_clr = (inv2_q == '0);
`else
    assign inv1_clr = 1'b1;
    assign inv2_clr = 1'b1;
`endif

    // hit_onN: fighter N takes damage at the coming frame edge.
    assign hit_on2 = (st1 == StActive) && !landed1 && (gap <= $signed({1'b0, info1.reach}))
                  && vert_ovl && !dead && !startscreen && inv2_clr;
    assign hit_on1 = (st2 == StActive) && !landed2 && (gap <= $signed({1'b0, info2.reach}))
                  && vert_ovl && !dead && !startscreen && inv1_clr;

    assign dmg2 = block_flag2 ? (info1.dmg >> BLOCK_SHIFT) : info1.dmg;
    assign dmg1 = block_flag1 ? (info2.dmg >> BLOCK_SHIFT) : info2.dmg;

    always_comb begin
        hp1_d  = hp1_q;
        hp2_d  = hp2_q;
        hit1_d = hit_on1;
        hit2_d = hit_on2;
        if (startscreen) begin
            hp1_d = 8'(MAX_HP);
            hp2_d = 8'(MAX_HP);
        end else begin
            if (hit_on1) begin
                hp1_d = (hp1_q > dmg1) ? hp1_q - dmg1 : '0;
            end
            if (hit_on2) begin
                hp2_d = (hp2_q > dmg2) ? hp2_q - dmg2 : '0;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            hp1_q  <= 8'(MAX_HP);
            hp2_q  <= 8'(MAX_HP);
            hit1_q <= 1'b0;
            hit2_q <= 1'b0;
        end else begin
            hp1_q  <= hp1_d;
            hp2_q  <= hp2_d;
            hit1_q <= hit1_d;
            hit2_q <= hit2_d;
        end
    end

`ifdef COMBAT_IFRAME_EN
    always_comb begin
        inv1_d = inv1_q;
        inv2_d = inv2_q;
        if (startscreen) begin
            inv1_d = '0;
            inv2_d = '0;
        end else begin
            if (hit_on1) begin
                inv1_d = InvW'(IFRAMES);
            end else if (!inv1_clr) begin
                inv1_d = inv1_q - 1'b1;
            end
            if (hit_on2) begin
                inv2_d = InvW'(IFRAMES);
            end else if (!inv2_clr) begin
                inv2_d = inv2_q - 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            inv1_q <= '0;
            inv2_q <= '0;
        end else begin
            inv1_q <= inv1_d;
            inv2_q <= inv2_d;
        end
    end
`endif

    attack_fsm u_fsm1 (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .startscreen_i(startscreen),
        .halt_i       (dead),
        .punch_i      (punch_flag1),
        .kick_i       (kick_flag1),
        .block_i      (block_flag1),
        .hit_landed_i (hit_on2),
        .state_o      (st1),
        .type_o       (ty1),
        .landed_o     (landed1)
    );

    attack_fsm u_fsm2 (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .startscreen_i(startscreen),
        .halt_i       (dead),
        .punch_i      (punch_flag2),
        .kick_i       (kick_flag2),
        .block_i      (block_flag2),
        .hit_landed_i (hit_on1),
        .state_o      (st2),
        .type_o       (ty2),
        .landed_o     (landed2)
    );

    assign hp1        = hp1_q;
    assign hp2        = hp2_q;
    assign deathL     = (hp1_q == '0);
    assign deathR     = (hp2_q == '0);
    assign hit1       = hit1_q;
    assign hit2       = hit2_q;
    assign atk_state1 = st1;
    assign atk_state2 = st2;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver: attack timing, reach, blocking, death, trades and reset.
// Expectations for the second and third trades follow COMBAT_IFRAME_EN.
module tb_combat_resolver;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b0;
    logic       startscreen = 1'b0;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic [9:0] p1_l, p1_r, p1_u, p1_d, p2_l, p2_r, p2_u, p2_d;
    logic       punch_flag1 = 0, kick_flag1 = 0, block_flag1 = 0;
    logic       punch_flag2 = 0, kick_flag2 = 0, block_flag2 = 0;
    logic [7:0] hp1, hp2;
    logic       deathL, deathR, hit1, hit2;
    logic [1:0] atk_state1, atk_state2;

    int total = 0;
    int bad   = 0;
    int n1, n2;

    combat_resolver dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .startscreen(startscreen),
        .p1_x       (p1_x),
        .p1_y       (p1_y),
        .p2_x       (p2_x),
        .p2_y       (p2_y),
        .p1_l       (p1_l),
        .p1_r       (p1_r),
        .p1_u       (p1_u),
        .p1_d       (p1_d),
        .p2_l       (p2_l),
        .p2_r       (p2_r),
        .p2_u       (p2_u),
        .p2_d       (p2_d),
        .punch_flag1(punch_flag1),
        .kick_flag1 (kick_flag1),
        .block_flag1(block_flag1),
        .punch_flag2(punch_flag2),
        .kick_flag2 (kick_flag2),
        .block_flag2(block_flag2),
        .hp1        (hp1),
        .hp2        (hp2),
        .deathL     (deathL),
        .deathR     (deathR),
        .hit1       (hit1),
        .hit2       (hit2),
        .atk_state1 (atk_state1),
        .atk_state2 (atk_state2)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One attack from a single-frame key press, run for the full 16-frame cycle.
    task automatic attack(input logic k1, input logic p1, input logic k2, input logic p2,
                          input logic b2, output int h1, output int h2);
        h1 = 0;
        h2 = 0;
        kick_flag1  = k1;
        punch_flag1 = p1;
        kick_flag2  = k2;
        punch_flag2 = p2;
        block_flag2 = b2;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin
                kick_flag1  = 0;
                punch_flag1 = 0;
                kick_flag2  = 0;
                punch_flag2 = 0;
            end
            h1 += int'(hit1);
            h2 += int'(hit2);
        end
        block_flag2 = 0;
    endtask

    initial begin
        p1_x = 150; p2_x = 250; p1_y = 300; p2_y = 300;
        p1_l = 45; p1_r = 45; p2_l = 45; p2_r = 45;
        p1_u = 50; p1_d = 50; p2_u = 50; p2_d = 50;

        #2 Reset = 1;
        #1;
        chk("rst_hp1", hp1, 100);
        chk("rst_hp2", hp2, 100);
        chk("rst_state1", atk_state1, 0);
        chk("rst_hit2", hit2, 0);
        tick();
        Reset = 0;
        repeat (5) tick();
        chk("idle_hp1", hp1, 100);
        chk("idle_hp2", hp2, 100);
        chk("idle_deathL", deathL, 0);
        chk("idle_deathR", deathR, 0);
        chk("idle_state1", atk_state1, 0);
        chk("idle_state2", atk_state2, 0);

        // Kick at gap 10: step through every phase.
        kick_flag1 = 1;
        tick();
        kick_flag1 = 0;
        chk("kick_windup1", atk_state1, 1);
        tick();
        tick();
        chk("kick_windup3", atk_state1, 1);
        tick();
        chk("kick_active", atk_state1, 2);
        chk("kick_nohit_yet", hit2, 0);
        tick();
        chk("kick_hit2", hit2, 1);
        chk("kick_hp2", hp2, 90);
        chk("kick_hit1", hit1, 0);
        chk("kick_active2", atk_state1, 2);
        tick();
        chk("kick_recover", atk_state1, 3);
        chk("kick_pulse_end", hit2, 0);
        repeat (9) tick();
        chk("kick_recover10", atk_state1, 3);
        tick();
        chk("kick_back_idle", atk_state1, 0);
        chk("kick_hp2_hold", hp2, 90);

        // Held blocked punch: one attack only, 5 >> 2 = 1 damage.
        block_flag2 = 1;
        punch_flag1 = 1;
        n2 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n2 += int'(hit2);
            if (i == 4) chk("hold_active", atk_state1, 2);
        end
        chk("hold_hits", n2, 1);
        chk("hold_hp2", hp2, 89);
        chk("hold_idle", atk_state1, 0);
        punch_flag1 = 0;
        block_flag2 = 0;
        tick();
        chk("hold_rearm_idle", atk_state1, 0);

        startscreen = 1;
        tick();
        startscreen = 0;
        chk("start_refill", hp2, 100);

        // Out of reach: gap 160.
        p2_x = 400;
        attack(1, 0, 0, 0, 0, n1, n2);
        chk("far_hits", n2, 0);
        chk("far_hp2", hp2, 100);
        chk("far_idle", atk_state1, 0);
        p2_x = 250;

        // Drain hp2 to 4, then a kick saturates it at 0.
        for (int k = 0; k < 9; k++) attack(1, 0, 0, 0, 0, n1, n2);
        chk("drain_hp2", hp2, 10);
        attack(0, 1, 0, 0, 0, n1, n2);
        chk("drain_punch", hp2, 5);
        attack(0, 1, 0, 0, 1, n1, n2);
        chk("drain_blocked", hp2, 4);
        attack(1, 0, 0, 0, 0, n1, n2);
        chk("sat_hp2", hp2, 0);
        chk("sat_deathR", deathR, 1);
        chk("sat_deathL", deathL, 0);
        chk("sat_hits", n2, 1);

        kick_flag1 = 1;
        kick_flag2 = 1;
        tick();
        chk("dead_idle1", atk_state1, 0);
        chk("dead_idle2", atk_state2, 0);
        kick_flag1 = 0;
        kick_flag2 = 0;
        tick();
        chk("dead_hp1", hp1, 100);

        startscreen = 1;
        tick();
        startscreen = 0;
        chk("revive_hp2", hp2, 100);
        chk("revive_deathR", deathR, 0);

        // Trade: both kick in the same frame.
        attack(1, 0, 1, 0, 0, n1, n2);
        chk("trade_hp1", hp1, 90);
        chk("trade_hp2", hp2, 90);
        chk("trade_hits1", n1, 1);
        chk("trade_hits2", n2, 1);

        attack(1, 0, 1, 0, 0, n1, n2);
`ifdef COMBAT_IFRAME_EN
        chk("trade2_hp1", hp1, 90);
        chk("trade2_hp2", hp2, 90);
`else
        chk("trade2_hp1", hp1, 80);
        chk("trade2_hp2", hp2, 80);
`endif
        attack(1, 0, 1, 0, 0, n1, n2);
`ifdef COMBAT_IFRAME_EN
        chk("trade3_hp1", hp1, 80);
        chk("trade3_hp2", hp2, 80);
`else
        chk("trade3_hp1", hp1, 70);
        chk("trade3_hp2", hp2, 70);
`endif

        // Asynchronous reset in the middle of an attack.
        kick_flag1 = 1;
        tick();
        kick_flag1 = 0;
        tick();
        #2 Reset = 1;
        #1;
        chk("midrst_state1", atk_state1, 0);
        chk("midrst_hp1", hp1, 100);
        chk("midrst_hp2", hp2, 100);
        tick();
        Reset = 0;
        tick();
        chk("post_rst_idle", atk_state1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
- Receiving end of the fighter attack-flag interface.
- Consumes each fighter's level punch/kick/block flags and hitboxes, once per frame_clk.
- Sequences each attack through windup/active/recovery, resolves hits against the opponent's hitbox, and maintains both health bars.
- Produces deathL/deathR, which feed back into both fighter movement controllers.

Parameters:
- MAX_HP, 100, starting/refill health per player (8-bit storage).
- PUNCH_DMG, 5, punch damage.
- KICK_DMG, 10, kick damage.
- BLOCK_SHIFT, 2, blocked damage = dmg >> BLOCK_SHIFT.
- PUNCH_REACH, 30, max horizontal gap in pixels for a punch hit.
- KICK_REACH, 45, max horizontal gap for a kick hit.
- WINDUP_FR, 3, frames in WINDUP.
- ACTIVE_FR, 2, frames in ACTIVE.
- RECOVER_FR, 10, frames in RECOVER.
- IFRAMES, 20, invulnerability frames (optional feature only).

Ports:
- frame_clk  in  1  frame clock
- Reset  in  1  asynchronous, active-high reset
- startscreen  in  1  title screen active
- p1_x, p1_y, p2_x, p2_y  in  10 each  fighter centres
- p1_l, p1_r, p1_u, p1_d  in  10 each  fighter 1 hitbox extents
- p2_l, p2_r, p2_u, p2_d  in  10 each  fighter 2 hitbox extents
- punch_flag1, kick_flag1, block_flag1  in  1 each  fighter 1 request levels
- punch_flag2, kick_flag2, block_flag2  in  1 each  fighter 2 request levels
- hp1, hp2  out  8 each  current health
- deathL  out  1  fighter 1 health is 0
- deathR  out  1  fighter 2 health is 0
- hit1, hit2  out  1 each  one-frame pulse: fighter N took damage this frame
- atk_state1, atk_state2  out  2 each  attack FSM state, for the sprite selector

Behaviour:
- Reset value of every output:
  - hp1 = hp2 = MAX_HP.
  - deathL, deathR, hit1, hit2 = 0.
  - atk_state1, atk_state2 = IDLE.
  - All counters 0; armed = 1.
- Registered outputs; the frame after a change is the first frame it is visible.
- Attack FSM, one per fighter; states IDLE=0, WINDUP=1, ACTIVE=2, RECOVER=3.
- IDLE -> WINDUP when armed & (kick|punch) & !block & !death & !startscreen.
  - Latch the attack type; kick wins if both flags are set. Clear armed.
- WINDUP holds for WINDUP_FR frames, then -> ACTIVE.
- ACTIVE holds for ACTIVE_FR frames, then -> RECOVER.
- RECOVER holds for RECOVER_FR frames, then -> IDLE.
- Each frame counter loads N-1 on entry and transitions at 0.
- armed sets again once punch and kick are both low for one frame. A held key therefore yields exactly one attack.
- Facing: fighter 1 faces right iff p1_x < p2_x, otherwise left. Fighter 2 faces the opposite way.
- Gap computation, 11-bit signed:
  - Facing right: gap = (def_x - def_l) - (atk_x + atk_r).
  - Facing left: gap = (atk_x - atk_l) - (def_x + def_r).
- Hit conditions, all required:
  - attacker is in ACTIVE;
  - gap <= reach (negative gap counts as a hit);
  - vertical overlap: atk_y + atk_d > def_y - def_u and def_y + def_d > atk_y - atk_u;
  - no hit already landed in this attack.
- Damage = type damage, or damage >> BLOCK_SHIFT if the defender's block flag is high that frame.
- hp saturates at 0 and never wraps.
- Each hit asserts the defender's hit pulse for exactly one frame. The attacker's hit-landed latch clears on entering WINDUP.
- Simultaneous hits (trade): both damages apply in the same frame.
- Death:
  - deathL = (hp1 == 0); deathR = (hp2 == 0).
  - Once either is set, no further damage is applied and both FSMs are forced to IDLE.
- startscreen high, in any state: both FSMs go to IDLE, hp refills to MAX_HP, deaths clear, pulses are 0, armed = 1.
- Reset mid-attack: asynchronous return to the reset values above.

Optional Feature:
- Macro COMBAT_IFRAME_EN.
- Defined: a hit loads the defender's invuln counter with IFRAMES.
  - While the counter is nonzero, hits on that defender are ignored and the attacker's hit-landed latch stays clear.
  - The counter decrements once per frame and clears on startscreen or Reset.
- Undefined: no counter; every qualifying hit applies damage.

Decomposition:
- Package combat_pkg:
  - atk_state_t enum (IDLE, WINDUP, ACTIVE, RECOVER);
  - atk_type_t (PUNCH, KICK);
  - damage and reach constants;
  - a function returning reach and damage for an atk_type_t.
- Sub-module attack_fsm, instantiated once per fighter. It owns the state, frame counter, armed bit, latched type and hit-landed latch.
- The top level holds the hit geometry, health registers, death logic and optional invuln counters.

Test Plan:
- Reset, then 5 idle frames -> hp1 = hp2 = 100, deaths 0, both states IDLE.
- p1_x=150, p2_x=250, both l=r=45: gap = 10. Pulse kick_flag1 for 1 frame -> WINDUP for 3 frames, ACTIVE, hit2 pulses once, hp2 = 90, RECOVER for 10 frames, IDLE.
- Same setup with block_flag2 held and a punch -> hp2 = 95 - 4... i.e. 5 >> 2 = 1, so hp2 = 99 after one punch from 100. Holding punch_flag1 for 40 frames -> exactly one attack.
- p2_x=400 (gap 160) and a kick -> full FSM cycle, no hit, hp2 stays 100.
- Preload hp2 = 4 via repeated hits, then a kick -> hp2 = 0, deathR = 1. Further kick/punch flags -> FSM stays IDLE. startscreen for 1 frame -> hp = 100, deathR = 0.
- Both fighters press kick in the same frame at gap 10 -> hp1 = hp2 = 90, and hit1/hit2 pulse in the same frame. With COMBAT_IFRAME_EN, a second kick 15 frames later does no damage; a kick after 20 frames does.
